// File: rtl/nmea_rx_ctrl_if.sv
// Signal bundle between nmea_rx_ctrl and its neighbours (char decoder, sentence receiver, result consumer).
// The i_si_filter signal exists only when NMEA_SI_FILTER_EN is defined.
interface nmea_rx_ctrl_if;
  logic [7:0]  i_char;
  logic        i_char_valid;
  logic [7:0]  o_rx_char;
  logic        o_rx_valid;
  logic        o_rx_abort;
  logic        i_done;
  logic        i_check_ok;
  logic [15:0] i_ti;
  logic [23:0] i_si;
  logic [7:0]  i_fieldcnt;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_ti;
  logic [23:0] o_si;
  logic [7:0]  o_fieldcnt;
  logic [15:0] o_good_cnt;
  logic [15:0] o_bad_cnt;
  logic [15:0] o_drop_cnt;
`ifdef NMEA_SI_FILTER_EN
  logic [23:0] i_si_filter;
`endif

  // Controller side.
  modport slave (
    input  i_char, i_char_valid, i_done, i_check_ok, i_ti, i_si, i_fieldcnt, i_ready,
    output o_rx_char, o_rx_valid, o_rx_abort, o_valid, o_ti, o_si, o_fieldcnt,
    output o_good_cnt, o_bad_cnt, o_drop_cnt
`ifdef NMEA_SI_FILTER_EN
    , input i_si_filter
`endif
  );

  // Environment side.
  modport master (
    output i_char, i_char_valid, i_done, i_check_ok, i_ti, i_si, i_fieldcnt, i_ready,
    input  o_rx_char, o_rx_valid, o_rx_abort, o_valid, o_ti, o_si, o_fieldcnt,
    input  o_good_cnt, o_bad_cnt, o_drop_cnt
`ifdef NMEA_SI_FILTER_EN
    , output i_si_filter
`endif
  );
endinterface

// File: rtl/nmea_rx_ctrl.sv
// NMEA receive sequencer: frames sentences on '$'/LF, aborts stalls and oversize, queues results.
// Define NMEA_SI_FILTER_EN to only accept sentences whose identifier matches i_si_filter (0 = any).
module nmea_rx_ctrl #(
  parameter int CHAR_TIMEOUT = 100000,
  parameter int RES_TIMEOUT  = 64,
  parameter int MAX_LEN      = 82,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  nmea_rx_ctrl_if.slave bus
);
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] LF     = 8'h0A;
  localparam int TMAX = (CHAR_TIMEOUT > RES_TIMEOUT) ? CHAR_TIMEOUT : RES_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;

  typedef enum logic [1:0] {HUNT, FRAME, WAIT} state_t;

  typedef struct packed {
    logic [15:0] ti;
    logic [23:0] si;
    logic [7:0]  fc;
  } entry_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr;
  logic [TW-1:0]   tmr_nx;
  logic [LW-1:0]   len;
  logic            fwd, abort, tmr_clr, tmr_inc, len_ld, len_inc, take;
  logic [7:0]      rx_char;
  logic            rx_valid, rx_abort;
  logic [15:0]     good_cnt, bad_cnt, drop_cnt;
  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wp, rp;
  logic            empty, full, pop, push, pass, ok_pass, bad_evt, drop_evt;
  entry_t          head;

  assign tmr_nx = tmr + TW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    abort     = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    len_ld    = 1'b0;
    len_inc   = 1'b0;
    take      = 1'b0;
    case (state)
      HUNT: begin
        if (bus.i_char_valid && bus.i_char == DOLLAR) begin
          fwd       = 1'b1;
          len_ld    = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = FRAME;
        end
      end
      FRAME: begin
        // Idle timer only advances on silent cycles, so a character always beats the timeout.
        if (!bus.i_char_valid) begin
          if (tmr_nx >= TW'(CHAR_TIMEOUT)) abort = 1'b1;
          else                             tmr_inc = 1'b1;
        end else if (bus.i_char == DOLLAR) begin
          abort = 1'b1;
        end else if (len >= LW'(MAX_LEN)) begin
          abort = 1'b1;
        end else begin
          fwd     = 1'b1;
          len_inc = 1'b1;
          tmr_clr = 1'b1;
          if (bus.i_char == LF) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.i_done) begin
          take      = 1'b1;
          state_nxt = HUNT;
        end else if (tmr_nx >= TW'(RES_TIMEOUT)) begin
          abort = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
    if (abort) state_nxt = HUNT;
  end

`ifdef NMEA_SI_FILTER_EN
  assign pass = (bus.i_si_filter == 24'd0) || (bus.i_si == bus.i_si_filter);
`else
  assign pass = 1'b1;
`endif

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop      = !empty && bus.i_ready;
  assign ok_pass  = take && bus.i_check_ok && pass;
  // A simultaneous pop frees the slot the push needs.
  assign push     = ok_pass && (!full || pop);
  assign drop_evt = ok_pass && full && !pop;
  assign bad_evt  = abort || (take && !bus.i_check_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmr      <= '0;
      len      <= '0;
      rx_char  <= 8'h00;
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      good_cnt <= 16'h0;
      bad_cnt  <= 16'h0;
      drop_cnt <= 16'h0;
      wp       <= '0;
      rp       <= '0;
    end else begin
      rx_valid <= fwd;
      rx_abort <= abort;
      if (fwd) rx_char <= bus.i_char;
      if (tmr_clr)      tmr <= '0;
      else if (tmr_inc) tmr <= tmr_nx;
      if (len_ld)       len <= LW'(1);
      else if (len_inc) len <= len + LW'(1);
      if (push && good_cnt != 16'hFFFF)     good_cnt <= good_cnt + 16'd1;
      if (bad_evt && bad_cnt != 16'hFFFF)   bad_cnt  <= bad_cnt + 16'd1;
      if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wp[AW-1:0]] <= '{ti: bus.i_ti, si: bus.i_si, fc: bus.i_fieldcnt};
  end

  // Head is masked while empty so stale entries never leak onto the outputs.
  assign head = empty ? entry_t'('0) : mem[rp[AW-1:0]];

  assign bus.o_rx_char  = rx_char;
  assign bus.o_rx_valid = rx_valid;
  assign bus.o_rx_abort = rx_abort;
  assign bus.o_valid    = !empty;
  assign bus.o_ti       = head.ti;
  assign bus.o_si       = head.si;
  assign bus.o_fieldcnt = head.fc;
  assign bus.o_good_cnt = good_cnt;
  assign bus.o_bad_cnt  = bad_cnt;
  assign bus.o_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_nmea_rx_ctrl.sv
// Self-checking bench for nmea_rx_ctrl: sentence-level reference model plus directed literal checks.
module tb_nmea_rx_ctrl;
  localparam int CT = 10, RT = 12, ML = 16, FD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  ch;
  logic        cv, done, ok, ready;
  logic [15:0] ti;
  logic [23:0] si;
  logic [7:0]  fc;

  nmea_rx_ctrl_if bus();
  assign bus.i_char       = ch;
  assign bus.i_char_valid = cv;
  assign bus.i_done       = done;
  assign bus.i_check_ok   = ok;
  assign bus.i_ti         = ti;
  assign bus.i_si         = si;
  assign bus.i_fieldcnt   = fc;
  assign bus.i_ready      = ready;
`ifdef NMEA_SI_FILTER_EN
  logic [23:0] filt;
  assign bus.i_si_filter = filt;
`endif

  nmea_rx_ctrl #(.CHAR_TIMEOUT(CT), .RES_TIMEOUT(RT), .MAX_LEN(ML), .FIFO_DEPTH(FD))
    dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int fwd_n = 0;
  int abort_n = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sentence-level view of the path, results kept in a queue.
  typedef struct { logic [15:0] ti; logic [23:0] si; logic [7:0] fc; } ent_t;
  ent_t q[$];
  bit   in_sent, await_res;
  int   idle, len;
  bit   e_rxv, e_abort;
  logic [7:0] e_rxc;
  int   e_good, e_bad, e_drop;

  function automatic int sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    bit   popq, pushq, kill, passes;
    ent_t e;
    if (rst) begin
      q.delete();
      in_sent = 0; await_res = 0; idle = 0; len = 0;
      e_rxv = 0; e_abort = 0; e_rxc = 8'h00;
      e_good = 0; e_bad = 0; e_drop = 0;
    end else begin
      popq = (q.size() != 0) && ready;
      pushq = 0; kill = 0;
      e_rxv = 0; e_abort = 0;
`ifdef NMEA_SI_FILTER_EN
      passes = (filt == 24'd0) || (si == filt);
`else
      passes = 1;
`endif
      if (await_res) begin
        if (done) begin
          if (!ok) e_bad = sat(e_bad);
          else if (passes) begin
            if (q.size() < FD || popq) begin pushq = 1; e_good = sat(e_good); end
            else e_drop = sat(e_drop);
          end
          await_res = 0;
        end else begin
          idle++;
          if (idle >= RT) kill = 1;
        end
      end else if (in_sent) begin
        if (!cv) begin
          idle++;
          if (idle >= CT) kill = 1;
        end else if (ch == 8'h24 || len >= ML) begin
          kill = 1;
        end else begin
          e_rxv = 1; e_rxc = ch; len++; idle = 0;
          if (ch == 8'h0A) begin in_sent = 0; await_res = 1; end
        end
      end else if (cv && ch == 8'h24) begin
        e_rxv = 1; e_rxc = ch; len = 1; idle = 0; in_sent = 1;
      end
      if (kill) begin
        e_abort = 1; in_sent = 0; await_res = 0; e_bad = sat(e_bad);
      end
      if (popq) void'(q.pop_front());
      if (pushq) begin
        e.ti = ti; e.si = si; e.fc = fc;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    chk("rx_valid", {31'd0, bus.o_rx_valid}, {31'd0, e_rxv});
    if (e_rxv) chk("rx_char", {24'd0, bus.o_rx_char}, {24'd0, e_rxc});
    chk("rx_abort", {31'd0, bus.o_rx_abort}, {31'd0, e_abort});
    chk("valid", {31'd0, bus.o_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("head_ti", {16'd0, bus.o_ti}, {16'd0, q[0].ti});
      chk("head_si", {8'd0, bus.o_si}, {8'd0, q[0].si});
      chk("head_fc", {24'd0, bus.o_fieldcnt}, {24'd0, q[0].fc});
    end
    chk("good_cnt", {16'd0, bus.o_good_cnt}, e_good);
    chk("bad_cnt", {16'd0, bus.o_bad_cnt}, e_bad);
    chk("drop_cnt", {16'd0, bus.o_drop_cnt}, e_drop);
    if (bus.o_rx_valid) fwd_n++;
    if (bus.o_rx_abort) abort_n++;
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; cv = 0; done = 0; ready = 0; ok = 0;
    cyc(2);
    rst = 0;
    fwd_n = 0; abort_n = 0;
  endtask

  task automatic send_char(logic [7:0] c);
    cv = 1; ch = c;
    cyc(1);
    cv = 0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic done_pulse(logic okv, logic [15:0] tiv, logic [23:0] siv, logic [7:0] fcv);
    done = 1; ok = okv; ti = tiv; si = siv; fc = fcv;
    cyc(1);
    done = 0;
  endtask

  localparam string GOOD = "$GPGGA,1,2*hh\015\n";

  initial begin
    ch = 8'h00; cv = 0; done = 0; ok = 0; ready = 0; ti = '0; si = '0; fc = '0;
`ifdef NMEA_SI_FILTER_EN
    filt = 24'd0;
`endif
    // Reset state, and a stray done while hunting changes nothing
    do_reset();
    cyc(1);
    chk("rst_rx_valid", {31'd0, bus.o_rx_valid}, 32'd0);
    chk("rst_rx_char", {24'd0, bus.o_rx_char}, 32'd0);
    chk("rst_rx_abort", {31'd0, bus.o_rx_abort}, 32'd0);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_ti", {16'd0, bus.o_ti}, 32'd0);
    chk("rst_si", {8'd0, bus.o_si}, 32'd0);
    chk("rst_fc", {24'd0, bus.o_fieldcnt}, 32'd0);
    chk("rst_good", {16'd0, bus.o_good_cnt}, 32'd0);
    done_pulse(1, 16'h4750, 24'h474741, 8'd3);
    cyc(2);
    chk("hunt_done_good", {16'd0, bus.o_good_cnt}, 32'd0);
    chk("hunt_done_valid", {31'd0, bus.o_valid}, 32'd0);

    // Good sentence
    do_reset();
    send_str(GOOD);
    done_pulse(1, 16'h4750, 24'h474741, 8'd3);
    cyc(1);
    chk("good_fwd", fwd_n, 32'd15);
    chk("good_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("good_si", {8'd0, bus.o_si}, 32'h474741);
    chk("good_cnt1", {16'd0, bus.o_good_cnt}, 32'd1);

    // Checksum fail, then back in hunt
    do_reset();
    send_str(GOOD);
    done_pulse(0, 16'h4750, 24'h474741, 8'd3);
    cyc(1);
    chk("bad_cnt1", {16'd0, bus.o_bad_cnt}, 32'd1);
    chk("bad_valid", {31'd0, bus.o_valid}, 32'd0);
    send_char(8'h24);
    cyc(1);
    chk("bad_rehunt_fwd", fwd_n, 32'd16);

    // Character timeout
    do_reset();
    send_str("$GP");
    cyc(12);
    chk("to_abort_n", abort_n, 32'd1);
    chk("to_bad", {16'd0, bus.o_bad_cnt}, 32'd1);
    chk("to_fwd", fwd_n, 32'd3);
    send_char(8'h24);
    cyc(1);
    chk("to_next_fwd", fwd_n, 32'd4);

    // Oversized sentence: 17th character is refused
    do_reset();
    send_str("$ABCDEFGHIJKLMNOP");
    cyc(2);
    chk("ovr_fwd", fwd_n, 32'd16);
    chk("ovr_abort_n", abort_n, 32'd1);

    // Result timeout: no done after LF
    do_reset();
    send_str(GOOD);
    cyc(RT + 2);
    chk("res_to_abort_n", abort_n, 32'd1);
    chk("res_to_bad", {16'd0, bus.o_bad_cnt}, 32'd1);

    // FIFO full, then push with simultaneous pop
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_str(GOOD);
      done_pulse(1, 16'h4750, 24'h474741, 8'(k + 1));
    end
    cyc(2);
    chk("full_drop", {16'd0, bus.o_drop_cnt}, 32'd1);
    chk("full_good", {16'd0, bus.o_good_cnt}, 32'd2);
    chk("full_head", {24'd0, bus.o_fieldcnt}, 32'd1);
    send_str(GOOD);
    ready = 1;
    done_pulse(1, 16'h4750, 24'h474741, 8'd4);
    ready = 0;
    cyc(1);
    chk("pp_good", {16'd0, bus.o_good_cnt}, 32'd3);
    chk("pp_drop", {16'd0, bus.o_drop_cnt}, 32'd1);
    chk("pp_head", {24'd0, bus.o_fieldcnt}, 32'd2);
    ready = 1;
    cyc(1);
    ready = 0;
    cyc(1);
    chk("pp_head2", {24'd0, bus.o_fieldcnt}, 32'd4);

`ifdef NMEA_SI_FILTER_EN
    // Identifier filter
    do_reset();
    filt = 24'h524D43;
    send_str(GOOD);
    done_pulse(1, 16'h4750, 24'h474741, 8'd3);
    cyc(2);
    chk("flt_valid0", {31'd0, bus.o_valid}, 32'd0);
    chk("flt_good0", {16'd0, bus.o_good_cnt}, 32'd0);
    chk("flt_bad0", {16'd0, bus.o_bad_cnt}, 32'd0);
    chk("flt_drop0", {16'd0, bus.o_drop_cnt}, 32'd0);
    send_str("$GPRMC,1*hh\015\n");
    done_pulse(1, 16'h4750, 24'h524D43, 8'd5);
    cyc(1);
    chk("flt_valid1", {31'd0, bus.o_valid}, 32'd1);
    chk("flt_good1", {16'd0, bus.o_good_cnt}, 32'd1);
    filt = 24'd0;
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 6000; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      cv    = ($urandom_range(0, 2) == 0);
      ch    = (r == 0) ? 8'h24 : (r == 1) ? 8'h0A : 8'(8'h41 + r);
      done  = ($urandom_range(0, 9) == 0);
      ok    = ($urandom_range(0, 3) != 0);
      ti    = 16'($urandom);
      si    = 24'($urandom_range(0, 3));
      fc    = 8'($urandom);
      ready = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 799) == 0);
`ifdef NMEA_SI_FILTER_EN
      filt  = 24'($urandom_range(0, 2));
`endif
      if ($urandom_range(0, 59) == 0) begin
        cv = 0; done = 0;
        cyc(int'($urandom_range(10, 14)));
      end else begin
        cyc(1);
      end
    end
    rst = 0; cv = 0; done = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
